// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcodes, ALU function codes, CONTROL codes and the
// sequencer state encoding. Imported by decode_ctrl, pc_next and the ALU.
package cpu_pkg;

  // Opcodes (instr[15:12]); 4'hD and 4'hE are unassigned and execute as NOP.
  localparam logic [3:0] OpNop    = 4'h0;
  localparam logic [3:0] OpArith2 = 4'h1;
  localparam logic [3:0] OpArith1 = 4'h2;
  localparam logic [3:0] OpMovi   = 4'h3;
  localparam logic [3:0] OpAddi   = 4'h4;
  localparam logic [3:0] OpSubi   = 4'h5;
  localparam logic [3:0] OpLoad   = 4'h6;
  localparam logic [3:0] OpStor   = 4'h7;
  localparam logic [3:0] OpBeq    = 4'h8;
  localparam logic [3:0] OpBge    = 4'h9;
  localparam logic [3:0] OpBle    = 4'hA;
  localparam logic [3:0] OpBc     = 4'hB;
  localparam logic [3:0] OpJ      = 4'hC;
  localparam logic [3:0] OpCtrl   = 4'hF;

  // ALU function field (instr[2:0]).
  localparam logic [2:0] AluAdd = 3'b000;
  localparam logic [2:0] AluAdc = 3'b001;
  localparam logic [2:0] AluSub = 3'b010;
  localparam logic [2:0] AluSbb = 3'b011;
  localparam logic [2:0] AluAnd = 3'b100;
  localparam logic [2:0] AluOr  = 3'b101;
  localparam logic [2:0] AluXor = 3'b110;
  localparam logic [2:0] AluNot = 3'b111;

  // CONTROL codes (instr[11:0]); any other code executes as NOP.
  localparam logic [11:0] CtrlStc   = 12'h001;
  localparam logic [11:0] CtrlStb   = 12'h002;
  localparam logic [11:0] CtrlReset = 12'hAAA;
  localparam logic [11:0] CtrlHalt  = 12'hFFF;

  typedef enum logic [1:0] {
    StFetch = 2'd0,
    StExec  = 2'd1,
    StMem   = 2'd2,
    StHalt  = 2'd3
  } state_e;

endpackage

// File: rtl/pc_next.sv
// Next-PC computation for the EXEC cycle (16-bit wrap-around).
//   pc_i      current PC
//   imm_i     6-bit signed branch offset
//   target_i  12-bit jump target (replaces PC[11:0])
//   branch_i  conditional branch taken
//   jump_i    unconditional jump
//   next_pc_o resulting PC
module pc_next
  import cpu_pkg::*;
(
  input  logic [15:0] pc_i,
  input  logic [5:0]  imm_i,
  input  logic [11:0] target_i,
  input  logic        branch_i,
  input  logic        jump_i,
  output logic [15:0] next_pc_o
);

  logic [15:0] pc_inc;
  logic [15:0] offset;

  assign pc_inc = pc_i + 16'd1;
  assign offset = {{10{imm_i[5]}}, imm_i};

  always_comb begin
    next_pc_o = pc_inc;
    if (jump_i) begin
      next_pc_o = {pc_i[15:12], target_i};
    end else if (branch_i) begin
      next_pc_o = pc_inc + offset;
    end
  end

endmodule

// File: rtl/decode_ctrl.sv
// Instruction fetch / decode / sequencing controller.
//   clk_pi, reset_n_pi          clock, async active-low reset
//   imem_*                      instruction fetch handshake (PC out, instruction in)
//   arith_*/addi/subi/load_or_store/stc_cmd/stb_cmd, alu_func, immediate  ALU controls
//   carry_*/borrow_*            ALU flag results in, registered flags out
//   rd/rs1/rs2_addr, rf_we      register file control
//   branch_taken_pi             external comparator result for BEQ/BGE/BLE
//   dmem_*                      data memory handshake
//   halted_po                   processor halted
module decode_ctrl
  import cpu_pkg::*;
(
  input  logic        clk_pi,
  input  logic        reset_n_pi,
  output logic        imem_req_po,
  output logic [15:0] imem_addr_po,
  input  logic        imem_valid_pi,
  input  logic [15:0] imem_data_pi,
  output logic        arith_1op_po,
  output logic        arith_2op_po,
  output logic        addi_po,
  output logic        subi_po,
  output logic        load_or_store_po,
  output logic        stc_cmd_po,
  output logic        stb_cmd_po,
  output logic [2:0]  alu_func_po,
  output logic [5:0]  immediate_po,
  input  logic        carry_out_pi,
  input  logic        borrow_out_pi,
  output logic        carry_flag_po,
  output logic        borrow_flag_po,
  output logic [2:0]  rd_addr_po,
  output logic [2:0]  rs1_addr_po,
  output logic [2:0]  rs2_addr_po,
  output logic        rf_we_po,
  input  logic        branch_taken_pi,
  output logic        dmem_req_po,
  output logic        dmem_we_po,
  input  logic        dmem_ack_pi,
  output logic        halted_po
);

  state_e      state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic [15:0] ir_q, ir_d;
  logic        carry_q, carry_d;
  logic        borrow_q, borrow_d;

  logic [3:0]  op;
  logic [11:0] code;
  logic        branch_taken;
  logic        jump;
  logic [15:0] pc_exec;

  assign op   = ir_q[15:12];
  assign code = ir_q[11:0];

  // BC tests the registered carry flag, i.e. the value before this EXEC's update.
  assign branch_taken = ((op == OpBeq) || (op == OpBge) || (op == OpBle)) ? branch_taken_pi :
                        (op == OpBc) ? carry_q : 1'b0;
  assign jump = (op == OpJ);

  pc_next u_pc_next (
    .pc_i      (pc_q),
    .imm_i     (ir_q[5:0]),
    .target_i  (ir_q[11:0]),
    .branch_i  (branch_taken),
    .jump_i    (jump),
    .next_pc_o (pc_exec)
  );

  assign imem_addr_po   = pc_q;
  assign carry_flag_po  = carry_q;
  assign borrow_flag_po = borrow_q;
  assign rd_addr_po     = ir_q[11:9];
  assign rs1_addr_po    = ir_q[8:6];
  assign rs2_addr_po    = ir_q[5:3];

  always_comb begin
    state_d          = state_q;
    pc_d             = pc_q;
    ir_d             = ir_q;
    carry_d          = carry_q;
    borrow_d         = borrow_q;
    imem_req_po      = 1'b0;
    arith_1op_po     = 1'b0;
    arith_2op_po     = 1'b0;
    addi_po          = 1'b0;
    subi_po          = 1'b0;
    load_or_store_po = 1'b0;
    stc_cmd_po       = 1'b0;
    stb_cmd_po       = 1'b0;
    alu_func_po      = 3'b000;
    immediate_po     = 6'd0;
    rf_we_po         = 1'b0;
    dmem_req_po      = 1'b0;
    dmem_we_po       = 1'b0;
    halted_po        = 1'b0;

    unique case (state_q)
      StFetch: begin
        // Reset forces StFetch; keep the request low until reset is released.
        imem_req_po = reset_n_pi;
        if (imem_valid_pi) begin
          ir_d    = imem_data_pi;
          state_d = StExec;
        end
      end

      StExec: begin
        // The ALU passes flags through when not generating, so always load them.
        carry_d  = carry_out_pi;
        borrow_d = borrow_out_pi;
        pc_d     = pc_exec;
        state_d  = StFetch;
        case (op)
          OpArith2: begin
            arith_2op_po = 1'b1;
            alu_func_po  = ir_q[2:0];
            rf_we_po     = 1'b1;
          end
          OpArith1: begin
            arith_1op_po = 1'b1;
            alu_func_po  = ir_q[2:0];
            rf_we_po     = 1'b1;
          end
          OpMovi: begin
            immediate_po = ir_q[5:0];
            rf_we_po     = 1'b1;
          end
          OpAddi: begin
            addi_po      = 1'b1;
            immediate_po = ir_q[5:0];
            rf_we_po     = 1'b1;
          end
          OpSubi: begin
            subi_po      = 1'b1;
            immediate_po = ir_q[5:0];
            rf_we_po     = 1'b1;
          end
          OpLoad, OpStor: begin
            load_or_store_po = 1'b1;
            immediate_po     = ir_q[5:0];
            pc_d             = pc_q;  // advanced when the memory access completes
            state_d          = StMem;
          end
          OpCtrl: begin
            case (code)
              CtrlStc:   stc_cmd_po = 1'b1;
              CtrlStb:   stb_cmd_po = 1'b1;
              CtrlReset: begin
                pc_d     = 16'd0;
                carry_d  = 1'b0;
                borrow_d = 1'b0;
              end
              CtrlHalt: begin
                pc_d    = pc_q;
                state_d = StHalt;
              end
              default: ;
            endcase
          end
          default: ;
        endcase
      end

      StMem: begin
        dmem_req_po      = 1'b1;
        dmem_we_po       = (op == OpStor);
        load_or_store_po = 1'b1;
        if (dmem_ack_pi) begin
          rf_we_po = (op == OpLoad);
          pc_d     = pc_q + 16'd1;
          state_d  = StFetch;
        end
      end

      StHalt: begin
        halted_po = 1'b1;
      end

      default: state_d = StFetch;
    endcase
  end

  always_ff @(posedge clk_pi or negedge reset_n_pi) begin
    if (!reset_n_pi) begin
      state_q  <= StFetch;
      pc_q     <= 16'd0;
      ir_q     <= 16'd0;
      carry_q  <= 1'b0;
      borrow_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      ir_q     <= ir_d;
      carry_q  <= carry_d;
      borrow_q <= borrow_d;
    end
  end

endmodule

// File: doc/decode_ctrl.md
DECODE_CTRL -- requirements
Module: decode_ctrl

Interface
REQ-001 SHALL have port: clk_pi  in  1  single clock; all state on rising edge.
REQ-002 SHALL have port: reset_n_pi  in  1  reset, asynchronous, active-low.
REQ-003 SHALL have ports: imem_req_po out 1 fetch request; imem_addr_po out 16 PC; imem_valid_pi in 1 fetch data valid; imem_data_pi in 16 instruction.
REQ-004 SHALL have ports to ALU: arith_1op_po, arith_2op_po, addi_po, subi_po, load_or_store_po, stc_cmd_po, stb_cmd_po out 1 each; alu_func_po out 3; immediate_po out 6.
REQ-005 SHALL have flag ports: carry_out_pi, borrow_out_pi in 1 (from ALU); carry_flag_po, borrow_flag_po out 1 (to ALU carry_in/borrow_in).
REQ-006 SHALL have ports: rd_addr_po, rs1_addr_po, rs2_addr_po out 3; rf_we_po out 1; branch_taken_pi in 1 (external comparator result for BEQ/BGE/BLE).
REQ-007 SHALL have ports: dmem_req_po out 1; dmem_we_po out 1 (1=store); dmem_ack_pi in 1; halted_po out 1.

Function
REQ-008 Instruction fields SHALL be: op[15:12], rd[11:9], rs1[8:6], rs2[5:3], func[2:0], imm[5:0], jump target[11:0], control code[11:0].
REQ-009 Opcodes SHALL be: NOP 0000, ARITH_2OP 0001, ARITH_1OP 0010, MOVI 0011, ADDI 0100, SUBI 0101, LOAD 0110, STOR 0111, BEQ 1000, BGE 1001, BLE 1010, BC 1011, J 1100, CONTROL 1111; 1101/1110 SHALL execute as NOP.
REQ-010 CONTROL codes SHALL be: STC 0x001, STB 0x002, RESET 0xAAA, HALT 0xFFF; any other code SHALL execute as NOP.
REQ-011 FSM states SHALL be FETCH, EXEC, MEM, HALT.
REQ-012 FETCH: imem_req_po=1, imem_addr_po=PC held stable until imem_valid_pi; on imem_valid_pi, latch instruction, go EXEC next cycle.
REQ-013 EXEC: exactly one cycle; ALU control outputs SHALL be one-hot-decoded from latched instruction; all ALU controls SHALL be 0 in every other state except load_or_store_po in MEM.
REQ-014 EXEC, end of cycle: carry_flag/borrow_flag SHALL load carry_out_pi/borrow_out_pi for every instruction (ALU propagates flags when not generating).
REQ-015 rf_we_po SHALL be 1 during EXEC for ARITH_2OP, ARITH_1OP, MOVI, ADDI, SUBI; during MEM only in the dmem_ack_pi cycle of LOAD.
REQ-016 MOVI: immediate_po=imm, rd written; ALU controls all 0.
REQ-017 LOAD/STOR: EXEC -> MEM; MEM asserts dmem_req_po and load_or_store_po until dmem_ack_pi, then PC+1, FETCH; ack arriving in the first MEM cycle SHALL complete in that cycle.
REQ-018 PC update in EXEC (16-bit wrap): default PC+1; BEQ/BGE/BLE taken when branch_taken_pi=1, BC taken when carry_flag_po=1 (pre-update value): PC+1+sign-extend(imm); J: {PC[15:12], target}.
REQ-019 HALT code: go HALT, halted_po=1, no further fetch; only reset exits HALT.
REQ-020 RESET code: PC=0, both flags=0, FETCH next cycle; stc/stb flags unaffected by the ALU result this cycle.
REQ-021 STC/STB: stc_cmd_po/stb_cmd_po=1 in EXEC; flag then updates via REQ-014.

Reset
REQ-022 On reset_n_pi=0, immediately: state FETCH, PC=0, flags 0, instruction register 0, all outputs 0 except imem_req_po (1 after release only); reset mid-fetch or mid-MEM SHALL abandon the transaction with no register write.

Structure
REQ-023 Opcode, ALU func, control-code constants and FSM state encoding SHALL live in shared package cpu_pkg, also used by alu.
REQ-024 Next-PC computation SHALL be sub-module pc_next (PC, imm, target, taken flags -> next PC).

Verification
REQ-025 Fetch 0x1242 (ADD r1,r1,r0... func 010=SUB) with imem_valid delayed 3 cycles -> imem_addr stable 4 cycles, arith_2op=1, alu_func=010 for one cycle, PC=1.
REQ-026 ADD with carry_out_pi=1 -> carry_flag_po=1 next cycle; following BC imm=0x3E at PC=5 -> PC=4.
REQ-027 LOAD with dmem_ack 2 cycles late -> dmem_req 3 cycles, rf_we one pulse at ack, PC+1.
REQ-028 J 0x123 at PC=0xF0FF -> PC=0xF123; ADDI at PC=0xFFFF -> PC=0x0000.
REQ-029 CONTROL 0xFFF -> halted_po=1, imem_req 0 for 20 cycles; reset -> PC=0, FETCH.
REQ-030 Reset asserted in MEM of STOR -> dmem_req drops same cycle, flags 0, fetch restarts at 0.
